// File: rtl/cache_ctrl_if.sv
// CPU request/response, tag array, dirty/LRU and AXI-master signals
// shared between the cache controller and its environment.
interface cache_ctrl_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int INDEX_SIZE = 7,
  parameter int CNT_W      = 32
);
  localparam int TAG_SIZE = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE;

  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_we;
  logic [ADDR_SIZE-1:0]  cpu_req_addr;
  logic                  cpu_resp_valid;
  logic                  cpu_resp_hit;
  logic [TAG_SIZE-1:0]   tag_o;
  logic [INDEX_SIZE-1:0] index_o;
  logic [2:0]            tag_replace;
  logic                  tag_match;
  logic                  tag_valid;
  logic                  victim_dirty;
  logic                  dirty_set;
  logic                  dirty_clr;
  logic                  lru_update;
  logic                  mem_wr_valid;
  logic                  mem_rd_valid;
  logic                  mem_req_ready;
  logic                  mem_done;
  logic [CNT_W-1:0]      hit_cnt;
  logic [CNT_W-1:0]      miss_cnt;
  logic [CNT_W-1:0]      wb_cnt;

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr,
    input  tag_match, tag_valid, victim_dirty,
    input  mem_req_ready, mem_done,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
    output tag_o, index_o, tag_replace,
    output dirty_set, dirty_clr, lru_update,
    output mem_wr_valid, mem_rd_valid,
    output hit_cnt, miss_cnt, wb_cnt
  );

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr,
    output tag_match, tag_valid, victim_dirty,
    output mem_req_ready, mem_done,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
    input  tag_o, index_o, tag_replace,
    input  dirty_set, dirty_clr, lru_update,
    input  mem_wr_valid, mem_rd_valid,
    input  hit_cnt, miss_cnt, wb_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Lookup/miss sequencing FSM for one set-associative cache path:
// lookup, write-back, fill, install, with hit/miss/write-back counters.
module cache_ctrl #(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int INDEX_SIZE = 7,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  cache_ctrl_if.slave bus
);
  localparam int TAG_SIZE = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE;
  localparam int LA_W     = ADDR_SIZE - BLOCK_SIZE;

  typedef enum logic [3:0] {
    INIT, IDLE, LOOKUP,
    WB_ADDR, WB_REQ, WB_WAIT,
    FILL_ADDR, FILL_REQ, FILL_WAIT,
    INSTALL, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [LA_W-1:0]  addr_q, addr_d;
  logic             we_q, we_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic             hit;
  logic [BLOCK_SIZE-1:0] unused_off;

  assign unused_off = bus.cpu_req_addr[BLOCK_SIZE-1:0];
  assign hit        = bus.tag_match & bus.tag_valid;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    unique case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (bus.cpu_req_valid) begin
          addr_d  = bus.cpu_req_addr[ADDR_SIZE-1:BLOCK_SIZE];
          we_d    = bus.cpu_req_we;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit;
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = RESP;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          // an invalid way holds nothing worth writing back
          state_d = (bus.tag_valid && bus.victim_dirty) ?
                    WB_ADDR : FILL_ADDR;
        end
      end
      WB_ADDR: state_d = WB_REQ;
      WB_REQ: begin
        if (bus.mem_req_ready) begin
          wb_cnt_d = sat_inc(wb_cnt_q);
          state_d  = WB_WAIT;
        end
      end
      WB_WAIT:   if (bus.mem_done) state_d = FILL_ADDR;
      FILL_ADDR: state_d = FILL_REQ;
      FILL_REQ:  if (bus.mem_req_ready) state_d = FILL_WAIT;
      FILL_WAIT: if (bus.mem_done) state_d = INSTALL;
      INSTALL:   state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      we_q       <= 1'b0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // latched address survives reset so the tag array inputs stay put
  always_ff @(posedge clk) begin
    if (!rst) addr_q <= addr_d;
  end

  assign bus.tag_o    = addr_q[LA_W-1 -: TAG_SIZE];
  assign bus.index_o  = addr_q[INDEX_SIZE-1:0];
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
  assign bus.wb_cnt   = wb_cnt_q;

  always_comb begin
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_hit   = 1'b0;
    bus.tag_replace    = 3'b111;
    bus.dirty_set      = 1'b0;
    bus.dirty_clr      = 1'b0;
    bus.lru_update     = 1'b0;
    bus.mem_wr_valid   = 1'b0;
    bus.mem_rd_valid   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        INIT: bus.tag_replace = 3'b000;
        IDLE: bus.cpu_req_ready = 1'b1;
        LOOKUP: begin
          bus.lru_update = hit;
          bus.dirty_set  = hit & we_q;
        end
        WB_ADDR:   bus.tag_replace  = 3'b010;
        WB_REQ:    bus.mem_wr_valid = 1'b1;
        FILL_ADDR: bus.tag_replace  = 3'b011;
        FILL_REQ:  bus.mem_rd_valid = 1'b1;
        INSTALL: begin
          bus.tag_replace = 3'b001;
          bus.lru_update  = 1'b1;
          bus.dirty_set   = we_q;
          bus.dirty_clr   = ~we_q;
        end
        RESP: begin
          bus.cpu_resp_valid = 1'b1;
          bus.cpu_resp_hit   = hit_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: vector table of lookups, memory responder,
// response scoreboard, and reset/back-to-back sequences.
module tb_cache_ctrl;
  logic clk;
  logic rst;
  int   cyc;

  cache_ctrl_if #(
    .ADDR_SIZE(32), .BLOCK_SIZE(6),
    .INDEX_SIZE(7), .CNT_W(32)
  ) bus ();

  cache_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic        match;
    logic        valid;
    logic        dirty;
    logic [3:0]  stall;
    logic        exp_hit;
    logic        exp_wb;
  } vec_t;

  typedef struct packed {
    logic hit;
    logic chk_lat;
    int   acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int checks, failures;
  int hit_m, miss_m, wb_m;
  int resp_n, resp_cyc, inst_cyc;
  int lru_n, dset_n, dclr_n, both_viol;
  int wr_cyc, rd_cyc, stall_cfg, stall_n, pend;
  bit hold_done, mon_en;
  logic [8:0] trace;
  int trace_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // memory side: stall ready, then pulse done two cycles later
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      bus.mem_done = 1'b0;
      bus.mem_req_ready = 1'b0;
      if (rst) begin
        pend = 0;
        stall_n = 0;
      end else if (bus.mem_wr_valid || bus.mem_rd_valid) begin
        if (bus.mem_wr_valid) wr_cyc++;
        else rd_cyc++;
        if (stall_n >= stall_cfg) begin
          bus.mem_req_ready = 1'b1;
          stall_n = 0;
          pend = hold_done ? 0 : 2;
        end else stall_n++;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) bus.mem_done = 1'b1;
      end
    end
  end

  // response scoreboard and event monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (bus.cpu_resp_valid) begin
          resp_n++;
          resp_cyc = cyc;
          chk("resp_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_hit", bus.cpu_resp_hit, e.hit);
            if (e.chk_lat) chk("hit_latency", cyc - e.acc, 2);
          end
        end
        if (mon_en && bus.tag_replace != 3'b111) begin
          trace = {trace[5:0], bus.tag_replace};
          trace_n++;
          if (bus.tag_replace == 3'b001) inst_cyc = cyc;
        end
        lru_n  += int'(bus.lru_update);
        dset_n += int'(bus.dirty_set);
        dclr_n += int'(bus.dirty_clr);
        if (bus.mem_wr_valid && bus.mem_rd_valid) both_viol++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

  task automatic accept_req(input logic we, input logic [31:0] addr,
                            output int acc, output bit ok);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we = we;
    bus.cpu_req_addr = addr;
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.cpu_req_ready) begin
        acc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 1, 0);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic run_req(input vec_t v, input int k);
    int acc, r0;
    bit ok;
    logic [8:0] exp_tr;
    int exp_n;
    bus.tag_match = v.match;
    bus.tag_valid = v.valid;
    bus.victim_dirty = v.dirty;
    stall_cfg = int'(v.stall);
    trace = '0; trace_n = 0;
    lru_n = 0; dset_n = 0; dclr_n = 0;
    wr_cyc = 0; rd_cyc = 0; inst_cyc = -10;
    r0 = resp_n;
    accept_req(v.we, v.addr, acc, ok);
    if (!ok) return;
    #1;
    chk($sformatf("v%0d_tag_o", k), bus.tag_o, v.addr[31:13]);
    chk($sformatf("v%0d_index_o", k), bus.index_o, v.addr[12:6]);
    sb.push_back('{hit: v.exp_hit, chk_lat: v.exp_hit, acc: acc});
    if (v.exp_hit) hit_m++;
    else begin
      miss_m++;
      if (v.exp_wb) wb_m++;
    end
    for (int i = 0; i < 300; i++) begin
      if (resp_n != r0) break;
      @(negedge clk); #3;
    end
    chk($sformatf("v%0d_resp_seen", k), resp_n - r0, 1);
    exp_tr = v.exp_hit ? 9'b000_000_000 :
             v.exp_wb  ? 9'b010_011_001 : 9'b000_011_001;
    exp_n  = v.exp_hit ? 0 : (v.exp_wb ? 3 : 2);
    chk($sformatf("v%0d_trace", k), trace, exp_tr);
    chk($sformatf("v%0d_trace_n", k), trace_n, exp_n);
    chk($sformatf("v%0d_lru", k), lru_n, 1);
    chk($sformatf("v%0d_dset", k), dset_n, int'(v.we));
    chk($sformatf("v%0d_dclr", k), dclr_n,
        int'(!v.exp_hit && !v.we));
    chk($sformatf("v%0d_wr_hold", k), wr_cyc,
        v.exp_wb ? int'(v.stall) + 1 : 0);
    chk($sformatf("v%0d_rd_hold", k), rd_cyc,
        v.exp_hit ? 0 : int'(v.stall) + 1);
    if (!v.exp_hit)
      chk($sformatf("v%0d_resp_after_install", k),
          resp_cyc - inst_cyc, 1);
    chk($sformatf("v%0d_hit_cnt", k), bus.hit_cnt, hit_m);
    chk($sformatf("v%0d_miss_cnt", k), bus.miss_cnt, miss_m);
    chk($sformatf("v%0d_wb_cnt", k), bus.wb_cnt, wb_m);
  endtask

  initial begin
    int acc, nacc, first, second;
    bit ok;
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr = '0;
    bus.tag_match = 1'b0;
    bus.tag_valid = 1'b0;
    bus.victim_dirty = 1'b0;
    stall_cfg = 0; hold_done = 1'b0; mon_en = 1'b0;

    //         we    addr          m     v     d     st    hit   wb
    vecs[0] = '{1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_1040, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0002_0080, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_1040, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_3000, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'hABCD_E000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h1234_5FC0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tag_replace", bus.tag_replace, 3'b111);
    chk("rst_ready", bus.cpu_req_ready, 0);
    rst = 1'b0;
    #1;
    chk("init_tag_replace", bus.tag_replace, 3'b000);
    chk("init_ready", bus.cpu_req_ready, 0);
    chk("init_hit_cnt", bus.hit_cnt, 0);
    chk("init_miss_cnt", bus.miss_cnt, 0);
    chk("init_wb_cnt", bus.wb_cnt, 0);
    @(negedge clk); #1;
    chk("idle_tag_replace", bus.tag_replace, 3'b111);
    chk("idle_ready", bus.cpu_req_ready, 1);
    mon_en = 1'b1;

    for (int k = 0; k < 8; k++) run_req(vecs[k], k);

    // reset while waiting for a fill burst
    hold_done = 1'b1;
    stall_cfg = 0;
    bus.tag_match = 1'b0;
    bus.tag_valid = 1'b0;
    bus.victim_dirty = 1'b0;
    rd_cyc = 0;
    accept_req(1'b0, 32'h0000_5040, acc, ok);
    repeat (4) @(negedge clk);
    #1;
    chk("fw_rd_handshake", rd_cyc, 1);
    chk("fw_rd_dropped", bus.mem_rd_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fw_rst_tag_replace", bus.tag_replace, 3'b000);
    chk("fw_rst_rd_valid", bus.mem_rd_valid, 0);
    chk("fw_rst_resp", bus.cpu_resp_valid, 0);
    chk("fw_rst_ready", bus.cpu_req_ready, 0);
    @(negedge clk); #1;
    chk("fw_idle_tag_replace", bus.tag_replace, 3'b111);
    chk("fw_idle_ready", bus.cpu_req_ready, 1);
    chk("fw_miss_cnt", bus.miss_cnt, 0);
    hit_m = 0; miss_m = 0; wb_m = 0;
    hold_done = 1'b0;

    // back-to-back hits with valid held high
    bus.tag_match = 1'b1;
    bus.tag_valid = 1'b1;
    first = -1; second = -1; nacc = 0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr = 32'h0000_1040;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.cpu_req_ready) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
        nacc++;
        hit_m++;
        sb.push_back('{hit: 1'b1, chk_lat: 1'b1, acc: cyc});
      end
      @(negedge clk);
    end
    bus.cpu_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("b2b_accepts", nacc, 4);
    chk("b2b_gap", second - first, 3);
    chk("b2b_hit_cnt", bus.hit_cnt, hit_m);
    chk("b2b_ready_idle", bus.cpu_req_ready, 1);

    // stray mem_done while idle
    @(negedge clk); #2;
    bus.mem_done = 1'b1;
    @(negedge clk); #3;
    chk("stray_ready", bus.cpu_req_ready, 1);
    chk("stray_tag_replace", bus.tag_replace, 3'b111);
    chk("stray_mem_valid", bus.mem_wr_valid | bus.mem_rd_valid, 0);
    chk("stray_miss_cnt", bus.miss_cnt, 0);

    chk("wr_rd_exclusive", both_viol, 0);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
